button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/watch_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 102 ++++++++++
 rtl/button_conditioner.sv | 60 ++++++
 tb/tb_button_conditioner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants and types for the watch pushbutton front end.
// Default cycle counts are derived from the 50 MHz system clock.
package watch_pkg;

   localparam int CLK_HZ                  = 50_000_000;
   localparam int DEBOUNCE_CYCLES_DEF     = CLK_HZ / 50;
   localparam int REPEAT_DELAY_CYCLES_DEF = CLK_HZ / 2;
   localparam int REPEAT_RATE_CYCLES_DEF  = CLK_HZ / 10;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } chan_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM, registered
// press pulse and held level, plus optional hold-to-repeat pulses.
module debounce_channel
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEF,
   parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEF,
   parameter bit REPEAT_EN           = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic pulse,
   output logic held
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX    = {DW{1'b1}};
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);
   localparam logic [RW-1:0] REP_MAX    = {RW{1'b1}};

   logic [1:0]    sync;
   logic          key_sync;
   chan_state_t   state;
   logic [DW-1:0] cnt;
   logic [RW-1:0] rcnt;
   logic          repeating;

   assign key_sync = sync[1];

   // The repeat timer first waits the long delay, then switches to the short rate.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync      <= 2'b11;
         state     <= RELEASED;
         cnt       <= '0;
         rcnt      <= '0;
         repeating <= 1'b0;
         pulse     <= 1'b0;
         held      <= 1'b0;
      end else begin
         sync  <= {sync[0], key_n};
         pulse <= 1'b0;
         case (state)
            RELEASED: begin
               cnt <= '0;
               if (!key_sync) state <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (key_sync) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state     <= PRESSED;
                  cnt       <= '0;
                  pulse     <= 1'b1;
                  held      <= 1'b1;
                  rcnt      <= '0;
                  repeating <= 1'b0;
               end else begin
                  cnt <= (cnt == DEB_MAX) ? cnt : cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (key_sync) begin
                  state     <= RELEASE_WAIT;
                  cnt       <= '0;
                  rcnt      <= '0;
                  repeating <= 1'b0;
               end else if (REPEAT_EN) begin
                  if (rcnt == (repeating ? RATE_LAST : DELAY_LAST)) begin
                     pulse     <= 1'b1;
                     rcnt      <= '0;
                     repeating <= 1'b1;
                  end else begin
                     rcnt <= (rcnt == REP_MAX) ? rcnt : rcnt + 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (!key_sync) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
                  held  <= 1'b0;
               end else begin
                  cnt <= (cnt == DEB_MAX) ? cnt : cnt + 1'b1;
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the three watch pushbuttons into press pulses and held levels;
// only the change key auto-repeats.
module button_conditioner
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEF,
   parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_mode_n,
   input  logic       key_start_n,
   input  logic       key_change_n,
   output logic       btn_mode,
   output logic       btn_start,
   output logic       btn_change,
   output logic [2:0] held
);

   debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_EN           (1'b0)
   ) u_mode (
      .clk   (clk),
      .reset (reset),
      .key_n (key_mode_n),
      .pulse (btn_mode),
      .held  (held[0])
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_EN           (1'b0)
   ) u_start (
      .clk   (clk),
      .reset (reset),
      .key_n (key_start_n),
      .pulse (btn_start),
      .held  (held[1])
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_EN           (1'b1)
   ) u_change (
      .clk   (clk),
      .reset (reset),
      .key_n (key_change_n),
      .pulse (btn_change),
      .held  (held[2])
   );

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulse
// cycles, a negedge monitor pops and compares whenever any pulse appears.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_mode_n;
   logic       key_start_n;
   logic       key_change_n;
   logic       btn_mode;
   logic       btn_start;
   logic       btn_change;
   logic [2:0] held;

   typedef struct {
      int         cyc;
      logic [2:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   button_conditioner #(
      .DEBOUNCE_CYCLES     (4),
      .REPEAT_DELAY_CYCLES (20),
      .REPEAT_RATE_CYCLES  (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_mode_n   (key_mode_n),
      .key_start_n  (key_start_n),
      .key_change_n (key_change_n),
      .btn_mode     (btn_mode),
      .btn_start    (btn_start),
      .btn_change   (btn_change),
      .held         (held)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every visible pulse must match the oldest queued expectation exactly.
   always @(negedge clk) begin
      logic [2:0] got;
      exp_t       e;
      got = {btn_change, btn_start, btn_mode};
      if (got != 3'b000) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_pulse: got=%b at cyc=%0d, none expected", got, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.mask != got) begin
               bad++;
               $display("[TB] FAIL pulse: got=%b at cyc=%0d, required=%b at cyc=%0d",
                        got, cyc, e.mask, e.cyc);
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input int at, input logic [2:0] mask);
      exp_t e;
      e.cyc  = at;
      e.mask = mask;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input string name, input logic [2:0] actual,
                               input logic [2:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: actual=%b required=%b", name, actual, required);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] keys_n);
      {key_change_n, key_start_n, key_mode_n} = keys_n;
   endtask

   initial begin
      int n;
      int pending;
      reset = 1'b1;
      apply_stimulus(3'b111);
      wait_cycles(2);
      check_output("reset_btn", {btn_change, btn_start, btn_mode}, 3'b000);
      check_output("reset_held", held, 3'b000);
      reset = 1'b0;
      wait_cycles(3);

      // clean mode press
      n = cyc + 1;
      expect_pulse(n + 6, 3'b001);
      apply_stimulus(3'b110);
      wait_cycles(30);
      check_output("clean_held", held, 3'b001);
      apply_stimulus(3'b111);
      wait_cycles(15);
      check_output("clean_released", held, 3'b000);

      // start key bouncing every 2 cycles
      for (int i = 0; i < 10; i++) begin
         apply_stimulus((i % 2 == 0) ? 3'b101 : 3'b111);
         wait_cycles(2);
         check_output("bounce_held", held, 3'b000);
      end
      apply_stimulus(3'b111);
      wait_cycles(10);
      check_output("bounce_after", held, 3'b000);

      // change key auto-repeat
      n = cyc + 1;
      expect_pulse(n + 6, 3'b100);
      expect_pulse(n + 26, 3'b100);
      expect_pulse(n + 31, 3'b100);
      expect_pulse(n + 36, 3'b100);
      expect_pulse(n + 41, 3'b100);
      expect_pulse(n + 46, 3'b100);
      apply_stimulus(3'b011);
      wait_cycles(49);
      apply_stimulus(3'b111);
      wait_cycles(30);
      check_output("repeat_released", held, 3'b000);

      // simultaneous press on all keys
      n = cyc + 1;
      expect_pulse(n + 6, 3'b111);
      apply_stimulus(3'b000);
      wait_cycles(10);
      check_output("simul_held", held, 3'b111);
      apply_stimulus(3'b111);
      wait_cycles(15);
      check_output("simul_released", held, 3'b000);

      // reset during mode debounce with the key kept low
      n = cyc + 1;
      apply_stimulus(3'b110);
      wait_cycles(3);
      reset = 1'b1;
      wait_cycles(2);
      expect_pulse(cyc + 1 + 6, 3'b001);
      reset = 1'b0;
      wait_cycles(15);
      check_output("rst_mid_held", held, 3'b001);
      apply_stimulus(3'b111);
      wait_cycles(15);
      check_output("rst_mid_released", held, 3'b000);

      // change key glitches high for 2 cycles after acceptance
      n = cyc + 1;
      expect_pulse(n + 6, 3'b100);
      apply_stimulus(3'b011);
      wait_cycles(12);
      apply_stimulus(3'b111);
      wait_cycles(2);
      apply_stimulus(3'b011);
      wait_cycles(1);
      check_output("glitch_held_a", held, 3'b100);
      wait_cycles(1);
      check_output("glitch_held_b", held, 3'b100);
      wait_cycles(4);
      check_output("glitch_held_c", held, 3'b100);
      apply_stimulus(3'b111);
      wait_cycles(15);
      check_output("glitch_released", held, 3'b000);

      wait_cycles(5);
      pending = exp_q.size();
      total++;
      if (pending != 0) begin
         bad++;
         $display("[TB] FAIL missing_pulses: actual=%0d outstanding required=0", pending);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
